// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the AXIS-to-FIFO packer: beat ratio, lane counter width and
// the lane-index mapping used by both lane orders.
package axis_fifo_pkg;

  localparam int unsigned LANE_MSB_FIRST = 0;
  localparam int unsigned LANE_LSB_FIRST = 1;

  function automatic int unsigned ratio_f(input int unsigned wide_w, input int unsigned narrow_w);
    return wide_w / narrow_w;
  endfunction

  function automatic int unsigned slot_width_f(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int unsigned lane_idx_f(input int unsigned slot, input int unsigned ratio,
                                             input int unsigned order);
    return (order == LANE_LSB_FIRST) ? slot : (ratio - 1 - slot);
  endfunction

endpackage

// File: rtl/axis_fifo_packer_if.sv
// Bundle of the narrow AXIS input and wide FIFO-write side of the packer.
// master: the surrounding source/FIFO; slave: the packer itself.
interface axis_fifo_packer_if #(
  parameter int unsigned FAW             = 8,
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH = 128
);
  logic                           S_AXIS_TVALID;
  logic                           S_AXIS_TREADY;
  logic [AXIS_DATA_WIDTH-1:0]     S_AXIS_TDATA;
  logic [AXIS_DATA_WIDTH/8-1:0]   S_AXIS_TSTRB;
  logic                           S_AXIS_TLAST;
  logic                           fwr_rdy;
  logic                           fwr_full;
  logic [FAW:0]                   fwr_cnt;
  logic                           fwr_vld;
  logic [AXI4_DATA_WIDTH-1:0]     fwr_dat;
  logic [AXI4_DATA_WIDTH/8-1:0]   fwr_strb;
  logic                           fwr_last;

  modport master (
    output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, fwr_rdy, fwr_full, fwr_cnt,
    input  S_AXIS_TREADY, fwr_vld, fwr_dat, fwr_strb, fwr_last
  );

  modport slave (
    input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, fwr_rdy, fwr_full, fwr_cnt,
    output S_AXIS_TREADY, fwr_vld, fwr_dat, fwr_strb, fwr_last
  );
endinterface

// File: rtl/axis_fifo_out_reg.sv
// Held-valid output register: loads a packed word, keeps it until the FIFO takes it.
// A load in the same cycle as a take replaces the word and keeps valid high.
module axis_fifo_out_reg #(
  parameter int unsigned DW = 128,
  parameter int unsigned SW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_dat,
  input  logic [SW-1:0] i_strb,
  input  logic          i_last,
  input  logic          i_rdy,
  input  logic          i_full,
  output logic          o_vld,
  output logic [DW-1:0] o_dat,
  output logic [SW-1:0] o_strb,
  output logic          o_last,
  output logic          o_take
);

  logic          r_vld;
  logic [DW-1:0] r_dat;
  logic [SW-1:0] r_strb;
  logic          r_last;

  assign o_take = r_vld & i_rdy & ~i_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld  <= 1'b0;
      r_dat  <= '0;
      r_strb <= '0;
      r_last <= 1'b0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_dat  <= i_dat;
      r_strb <= i_strb;
      r_last <= i_last;
    end else if (o_take) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_vld  = r_vld;
  assign o_dat  = r_dat;
  assign o_strb = r_strb;
  assign o_last = r_last;

endmodule

// File: rtl/axis_fifo_packer.sv
// Packs RATIO narrow AXIS beats into one wide FIFO word with byte strobes.
// Define AXIS_FIFO_PACKER_TLAST_FLUSH_EN to let TLAST close a partial word early.
module axis_fifo_packer
  import axis_fifo_pkg::*;
#(
  parameter int unsigned FAW             = 8,
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH = 128,
  parameter int unsigned LANE_ORDER      = LANE_MSB_FIRST,
  parameter int unsigned AF_MARGIN       = 2
) (
  input logic               S_AXIS_ACLK,
  input logic               S_AXIS_ARESETN,
  axis_fifo_packer_if.slave io_bus
);

  localparam int unsigned Ratio    = ratio_f(AXI4_DATA_WIDTH, AXIS_DATA_WIDTH);
  localparam int unsigned SlotW    = slot_width_f(Ratio);
  localparam int unsigned NStrbW   = AXIS_DATA_WIDTH / 8;
  localparam int unsigned WStrbW   = AXI4_DATA_WIDTH / 8;
  localparam int unsigned AfThresh = (2 ** FAW) - AF_MARGIN;
  localparam logic [FAW:0] AfThreshV = AfThresh[FAW:0];

  logic [AXI4_DATA_WIDTH-1:0] r_buf;
  logic [WStrbW-1:0]          r_sbuf;
  logic [SlotW-1:0]           r_slot;

  logic                       w_af;
  logic                       w_vld;
  logic                       w_take;
  logic                       w_tready;
  logic                       w_accept;
  logic                       w_top;
  logic                       w_complete;
  int unsigned                w_lane;
  logic [AXI4_DATA_WIDTH-1:0] w_dat;
  logic [WStrbW-1:0]          w_strb;

  assign w_af     = (io_bus.fwr_cnt >= AfThreshV);
  // Gated by reset so the source never sees ready while the block is held in reset.
  assign w_tready = S_AXIS_ARESETN & ~w_af & (~w_vld | w_take);
  assign w_accept = io_bus.S_AXIS_TVALID & w_tready;
  assign w_top    = (32'(r_slot) == (Ratio - 1));
  assign w_lane   = lane_idx_f(32'(r_slot), Ratio, LANE_ORDER);

`ifdef AXIS_FIFO_PACKER_TLAST_FLUSH_EN
  assign w_complete = w_top | io_bus.S_AXIS_TLAST;
`else
  assign w_complete = w_top;
`endif

  // Buffer merged with the current beat; this is both the next buffer and the output word.
  always_comb begin
    w_dat  = r_buf;
    w_strb = r_sbuf;
    for (int unsigned l = 0; l < Ratio; l++) begin
      if (l == w_lane) begin
        w_dat[l*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = io_bus.S_AXIS_TDATA;
        w_strb[l*NStrbW +: NStrbW]                  = io_bus.S_AXIS_TSTRB;
      end
    end
  end

  // Clearing data as well as strobes leaves unfilled lanes of a flushed word at zero.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      r_buf  <= '0;
      r_sbuf <= '0;
      r_slot <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_buf  <= '0;
        r_sbuf <= '0;
        r_slot <= '0;
      end else begin
        r_buf  <= w_dat;
        r_sbuf <= w_strb;
        r_slot <= r_slot + SlotW'(1);
      end
    end
  end

  axis_fifo_out_reg #(
    .DW(AXI4_DATA_WIDTH),
    .SW(WStrbW)
  ) u_out_reg (
    .i_clk  (S_AXIS_ACLK),
    .i_rst_n(S_AXIS_ARESETN),
    .i_load (w_accept & w_complete),
    .i_dat  (w_dat),
    .i_strb (w_strb),
    .i_last (io_bus.S_AXIS_TLAST),
    .i_rdy  (io_bus.fwr_rdy),
    .i_full (io_bus.fwr_full),
    .o_vld  (w_vld),
    .o_dat  (io_bus.fwr_dat),
    .o_strb (io_bus.fwr_strb),
    .o_last (io_bus.fwr_last),
    .o_take (w_take)
  );

  assign io_bus.fwr_vld       = w_vld;
  assign io_bus.S_AXIS_TREADY = w_tready;

endmodule

// File: tb/tb_axis_fifo_packer.sv
// Randomized and directed bench for axis_fifo_packer: both lane orders side by side,
// checked every cycle against a queue-based word model.
module tb_axis_fifo_packer;

  localparam int unsigned Ratio = 4;
`ifdef AXIS_FIFO_PACKER_TLAST_FLUSH_EN
  localparam bit Flush = 1'b1;
`else
  localparam bit Flush = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tvalid = 1'b0;
  logic [31:0] tdata = '0;
  logic [3:0]  tstrb = '0;
  logic        tlast = 1'b0;
  logic        rdy = 1'b0;
  logic        full = 1'b0;
  logic [8:0]  cnt = '0;

  // Staged controls, applied just after the next rising edge.
  logic        s_rstn = 1'b0;
  logic        s_rdy = 1'b1;
  logic        s_full = 1'b0;
  logic [8:0]  s_cnt = '0;

  int n_checks = 0;
  int n_errors = 0;

  beat_t        q[$];
  logic         m_vld;
  logic [127:0] m_dat0, m_dat1;
  logic [15:0]  m_strb0, m_strb1;
  logic         m_last;
  logic         m_acc;
  int           m_takes = 0;
  int           dut_takes = 0;

  always #5 clk = ~clk;

  axis_fifo_packer_if #(.FAW(8), .AXIS_DATA_WIDTH(32), .AXI4_DATA_WIDTH(128)) bus0 ();
  axis_fifo_packer_if #(.FAW(8), .AXIS_DATA_WIDTH(32), .AXI4_DATA_WIDTH(128)) bus1 ();

  assign bus0.S_AXIS_TVALID = tvalid;
  assign bus0.S_AXIS_TDATA  = tdata;
  assign bus0.S_AXIS_TSTRB  = tstrb;
  assign bus0.S_AXIS_TLAST  = tlast;
  assign bus0.fwr_rdy       = rdy;
  assign bus0.fwr_full      = full;
  assign bus0.fwr_cnt       = cnt;
  assign bus1.S_AXIS_TVALID = tvalid;
  assign bus1.S_AXIS_TDATA  = tdata;
  assign bus1.S_AXIS_TSTRB  = tstrb;
  assign bus1.S_AXIS_TLAST  = tlast;
  assign bus1.fwr_rdy       = rdy;
  assign bus1.fwr_full      = full;
  assign bus1.fwr_cnt       = cnt;

  axis_fifo_packer #(
    .FAW(8), .AXIS_DATA_WIDTH(32), .AXI4_DATA_WIDTH(128), .LANE_ORDER(0), .AF_MARGIN(2)
  ) u_dut0 (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rstn),
    .io_bus        (bus0)
  );

  axis_fifo_packer #(
    .FAW(8), .AXIS_DATA_WIDTH(32), .AXI4_DATA_WIDTH(128), .LANE_ORDER(1), .AF_MARGIN(2)
  ) u_dut1 (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rstn),
    .io_bus        (bus1)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_vld   = 1'b0;
    m_dat0  = '0;
    m_dat1  = '0;
    m_strb0 = '0;
    m_strb1 = '0;
    m_last  = 1'b0;
  endtask

  // Word = beats in arrival order; order 0 puts beat i in lane 3-i, order 1 in lane i.
  task automatic model_complete(input logic last);
    m_dat0 = '0; m_dat1 = '0; m_strb0 = '0; m_strb1 = '0;
    for (int i = 0; i < q.size(); i++) begin
      m_dat0[(Ratio-1-i)*32 +: 32] = q[i].d;
      m_strb0[(Ratio-1-i)*4 +: 4]  = q[i].s;
      m_dat1[i*32 +: 32]           = q[i].d;
      m_strb1[i*4 +: 4]            = q[i].s;
    end
    m_last = last;
    m_vld  = 1'b1;
    q.delete();
  endtask

  task automatic evaluate();
    logic exp_af, exp_take, exp_tready;
    beat_t b;
    if (!rstn) model_reset();
    exp_af     = (cnt >= 9'd254);
    exp_take   = m_vld & rdy & ~full;
    exp_tready = rstn & ~exp_af & (~m_vld | exp_take);
    chk("tready0", bus0.S_AXIS_TREADY, exp_tready);
    chk("tready1", bus1.S_AXIS_TREADY, exp_tready);
    chk("vld0", bus0.fwr_vld, m_vld);
    chk("vld1", bus1.fwr_vld, m_vld);
    chk("dat0", bus0.fwr_dat, m_dat0);
    chk("dat1", bus1.fwr_dat, m_dat1);
    chk("strb0", bus0.fwr_strb, m_strb0);
    chk("strb1", bus1.fwr_strb, m_strb1);
    chk("last0", bus0.fwr_last, m_last);
    chk("last1", bus1.fwr_last, m_last);
    if (bus0.fwr_vld & rdy & ~full) dut_takes++;
    if (exp_take) m_takes++;
    m_acc = exp_tready & tvalid;
    if (m_acc) begin
      b.d = tdata; b.s = tstrb; b.l = tlast;
      q.push_back(b);
      if (q.size() == Ratio || (Flush && tlast)) model_complete(tlast);
      else if (exp_take) m_vld = 1'b0;
    end else if (exp_take) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] d, input logic [3:0] s, input logic l);
    @(posedge clk);
    #1;
    tvalid = v; tdata = d; tstrb = s; tlast = l;
    rdy = s_rdy; full = s_full; cnt = s_cnt; rstn = s_rstn;
    @(negedge clk);
    evaluate();
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    do begin
      cycle(1'b1, d, 4'hF, l);
      n++;
    end while (!m_acc && n < 50);
    chk("send_accept", m_acc, 1'b1);
  endtask

  task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] d);
    send_beat(a, 1'b0); send_beat(b, 1'b0); send_beat(c, 1'b0); send_beat(d, 1'b0);
  endtask

  initial begin
    model_reset();
    m_acc = 1'b0;
    repeat (3) idle();
    chk("rst_tready", bus0.S_AXIS_TREADY, 1'b0);
    chk("rst_dat", bus0.fwr_dat, 128'h0);
    s_rstn = 1'b1;
    idle();

    // Basic packing in both lane orders.
    send4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    idle();
    chk("word_msb", bus0.fwr_dat, 128'h11111111_22222222_33333333_44444444);
    chk("word_lsb", bus1.fwr_dat, 128'h44444444_33333333_22222222_11111111);
    chk("word_strb", bus0.fwr_strb, 16'hFFFF);
    chk("word_vld", bus0.fwr_vld, 1'b1);
    idle();

    // Output back-pressure: word held, input stalled, nothing lost.
    s_rdy = 1'b0;
    send4(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h99999999, 4'hF, 1'b0);
      chk("stall_tready", bus0.S_AXIS_TREADY, 1'b0);
      chk("stall_dat", bus0.fwr_dat, 128'h55555555_66666666_77777777_88888888);
    end
    s_rdy = 1'b1;
    send4(32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC);
    idle();
    chk("after_stall", bus1.fwr_dat, 128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_99999999);
    idle();

    // Almost-full stalls input mid-word and keeps the partial word.
    send_beat(32'hA1A1A1A1, 1'b0);
    send_beat(32'hA2A2A2A2, 1'b0);
    s_cnt = 9'd254;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hA3A3A3A3, 4'hF, 1'b0);
      chk("af_tready", bus0.S_AXIS_TREADY, 1'b0);
    end
    s_cnt = 9'd253;
    send_beat(32'hA3A3A3A3, 1'b0);
    send_beat(32'hA4A4A4A4, 1'b0);
    idle();
    chk("af_word", bus0.fwr_dat, 128'hA1A1A1A1_A2A2A2A2_A3A3A3A3_A4A4A4A4);
    s_cnt = 9'd0;

    // Reset mid-word discards the partial word.
    send_beat(32'hDEADBEEF, 1'b0);
    send_beat(32'hCAFEF00D, 1'b0);
    s_rstn = 1'b0;
    idle();
    chk("rst_mid_vld", bus0.fwr_vld, 1'b0);
    s_rstn = 1'b1;
    idle();
    send4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    idle();
    chk("post_rst_word", bus0.fwr_dat, 128'h11111111_22222222_33333333_44444444);

`ifdef AXIS_FIFO_PACKER_TLAST_FLUSH_EN
    send_beat(32'h0000000A, 1'b0);
    send_beat(32'h0000000B, 1'b1);
    idle();
    chk("flush_dat", bus0.fwr_dat, 128'h0000000A_0000000B_00000000_00000000);
    chk("flush_strb", bus0.fwr_strb, 16'hFF00);
    chk("flush_last", bus0.fwr_last, 1'b1);
    send4(32'h1, 32'h2, 32'h3, 32'h4);
    idle();
    chk("flush_next", bus0.fwr_dat, 128'h00000001_00000002_00000003_00000004);
`else
    send_beat(32'h0000000A, 1'b0);
    send_beat(32'h0000000B, 1'b1);
    send_beat(32'h0000000C, 1'b0);
    send_beat(32'h0000000D, 1'b1);
    idle();
    chk("nf_dat", bus0.fwr_dat, 128'h0000000A_0000000B_0000000C_0000000D);
    chk("nf_last", bus0.fwr_last, 1'b1);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s_rdy  = ($urandom_range(0, 4) != 0);
      s_full = ($urandom_range(0, 9) == 0);
      s_cnt  = ($urandom_range(0, 7) == 0) ? 9'(250 + $urandom_range(0, 6))
                                           : 9'($urandom_range(0, 249));
      s_rstn = ($urandom_range(0, 499) != 0);
      cycle($urandom_range(0, 3) != 0, $urandom, 4'($urandom), $urandom_range(0, 3) == 0);
    end

    s_rstn = 1'b1; s_rdy = 1'b1; s_full = 1'b0; s_cnt = '0;
    repeat (4) idle();
    chk("take_count", 128'(dut_takes), 128'(m_takes));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
